sdram_wb_arbiter: RTL
=====================

Name: sdram_wb_arbiter

Overview:
Two-requester Wishbone arbiter that shares the single SDRAM Wishbone port of convnet.
- Requester 0 is the USB ingest path (FX2 slave-FIFO → SDRAM writes).
- Requester 1 is the convolution engine (weight/feature reads, result writes).
- It uses round-robin grant, one classic single-beat Wishbone cycle per grant, and returns read data plus a one-cycle ack pulse to the granted requester.
- It sits between the requester blocks and the SDRAM controller.

Parameters:
- AW, 32, address width of addr_i and m*_addr
- DW, 32, data width of data_i, data_o and m*_wdata/m*_rdata
- SW, 4, byte-select width (DW/8)
- TIMEOUT, 64, cycles to wait for sdram_ack before abort (only used under ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  USB requester: level request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read
- m0_sel  in  SW  byte selects
- m0_addr  in  AW  word address
- m0_wdata  in  DW  write data
- m0_rdata  out  DW  read data, valid when m0_ack=1
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0_*, conv-engine requester
- cyc_i  out  1  Wishbone cycle to SDRAM
- stb_i  out  1  Wishbone strobe
- we_i  out  1  Wishbone write enable
- sel_i  out  SW  Wishbone byte select
- addr_i  out  AW  Wishbone address
- data_i  out  DW  Wishbone write data
- data_o  in  DW  SDRAM read data (may be Z outside ack)
- stall_o  in  1  SDRAM stall
- sdram_ack  in  1  SDRAM ack; level, held while cyc_i=1 and for one cycle after cyc_i falls
- gnt  out  2  one-hot current owner, 00 when idle
- m_err  out  2  per-requester timeout pulse (00 when ARB_TIMEOUT_EN undefined)

Behaviour:
- Reset: every output is 0, including m*_rdata and the Wishbone bus. FSM goes to IDLE and last_gnt=1, so m0 wins the first tie.
- All outputs are registered. Reset mid-transaction drops cyc_i/stb_i at the reset edge, issues no ack, and discards the transaction.
- States: IDLE, BUS, RELEASE.
- IDLE:
  - On an edge with any req=1, choose the owner: sole requester, or on a tie the one ≠ last_gnt.
  - Latch that requester's we/sel/addr/wdata onto the Wishbone outputs.
  - Set cyc_i=stb_i=1, set gnt, update last_gnt, go to BUS.
- BUS:
  - Hold cyc_i, stb_i and all latched fields constant; stall_o=1 only extends the hold.
  - Requester inputs are ignored after latching.
  - On an edge with sdram_ack=1 and stall_o=0: capture data_o into the owner's m*_rdata (reads only; writes leave rdata unchanged), pulse the owner's m*_ack for exactly one cycle, clear cyc_i/stb_i/gnt, go to RELEASE.
- RELEASE: stay until sampled sdram_ack=0 (minimum 1 cycle, 2 with the held-ack SDRAM model), then go to IDLE. No grant is issued while ack is still high.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1…
- A requester dropping req during BUS still receives its ack pulse. A requester re-asserting req in the cycle after its ack is legal; it competes normally.
- m*_ack is never asserted for the non-owner. Both acks are never high together.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter clears on entry to BUS and increments each BUS cycle.
  - On reaching TIMEOUT−1 without ack, drop cyc_i/stb_i, pulse the owner's m_err bit for 1 cycle (no m*_ack), go to RELEASE.
  - Counter width is $clog2(TIMEOUT).
- Undefined: no counter; m_err is tied to 0; BUS waits indefinitely.

Decomposition:
- Shared package sdram_arb_pkg: state encoding constants (IDLE/BUS/RELEASE), requester index constants (REQ_USB=0, REQ_CONV=1), default AW/DW/SW.
- One sub-module, rr_arb2: a combinational two-input round-robin picker taking req[1:0] and last_gnt and returning a one-hot grant.

Test Plan:
- Single read: preload SDRAM[5]=32'hDEADBEEF; m1_req read, addr=5 → one m1_ack pulse with m1_rdata=32'hDEADBEEF; m0_ack stays 0; cyc_i low the cycle after the ack.
- Write then read-back: m0 writes 32'h12345678 to addr 3 with sel=4'hF, then m1 reads addr 3 → m1_rdata=32'h12345678; sdram[3] matches.
- Simultaneous req from reset, both held for 4 transactions → gnt sequence 01,10,01,10; exactly 2 acks each.
- Held ack: after each ack, assert that cyc_i stays 0 until sdram_ack is sampled 0 (≥2 cycles); no new stb_i before then.
- Stall: hold stall_o=1 for 10 cycles during BUS → addr_i/data_i/stb_i unchanged throughout; completion only after release.
- Reset mid-BUS: assert rst during BUS → next edge all outputs 0, no m*_ack. With ARB_TIMEOUT_EN and TIMEOUT=16, a never-acking slave → m_err pulse for the owner after 16 BUS cycles, cyc_i dropped.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM Wishbone arbiter: FSM state encoding,
// requester indices and default bus widths.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int REQ_USB  = 0;
    localparam int REQ_CONV = 1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_SW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-input round-robin picker: a sole requester wins,
// and a tie goes to the requester that did not own the previous grant.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last_gnt ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Round-robin arbiter sharing one single-beat Wishbone SDRAM port between the
// USB ingest path (m0) and the conv engine (m1). Optional feature: ARB_TIMEOUT_EN.
module sdram_wb_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int SW      = DEF_SW,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [SW-1:0] m0_sel,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [SW-1:0] m1_sel,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          cyc_i,
    output logic          stb_i,
    output logic          we_i,
    output logic [SW-1:0] sel_i,
    output logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_i,
    input  logic [DW-1:0] data_o,
    input  logic          stall_o,
    input  logic          sdram_ack,
    output logic [1:0]    gnt,
    output logic [1:0]    m_err
);

    arb_state_t    r_state, w_state_nxt;
    logic          r_cyc, w_cyc_nxt;
    logic          r_we, w_we_nxt;
    logic [SW-1:0] r_sel, w_sel_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic [DW-1:0] r_rdata0, w_rdata0_nxt;
    logic [DW-1:0] r_rdata1, w_rdata1_nxt;
    logic [1:0]    r_ack, w_ack_nxt;
    logic [1:0]    r_gnt, w_gnt_nxt;
    logic          r_last, w_last_nxt;
    logic          r_own, w_own_nxt;
    logic [1:0]    w_pick;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_err, w_err_nxt;
`else
    logic          w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT > 0);
`endif

    rr_arb2 u_pick (
        .i_req      ({m1_req, m0_req}),
        .i_last_gnt (r_last),
        .o_gnt      (w_pick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_we_nxt     = r_we;
        w_sel_nxt    = r_sel;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_ack_nxt    = 2'b00;
        w_gnt_nxt    = r_gnt;
        w_last_nxt   = r_last;
        w_own_nxt    = r_own;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 2'b00;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick != 2'b00) begin
                    w_own_nxt   = w_pick[1];
                    w_last_nxt  = w_pick[1];
                    w_gnt_nxt   = w_pick;
                    w_cyc_nxt   = 1'b1;
                    w_state_nxt = ST_BUS;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                    if (w_pick[1]) begin
                        w_we_nxt    = m1_we;
                        w_sel_nxt   = m1_sel;
                        w_addr_nxt  = m1_addr;
                        w_wdata_nxt = m1_wdata;
                    end else begin
                        w_we_nxt    = m0_we;
                        w_sel_nxt   = m0_sel;
                        w_addr_nxt  = m0_addr;
                        w_wdata_nxt = m0_wdata;
                    end
                end
            end
            ST_BUS: begin
                if (sdram_ack && !stall_o) begin
                    if (!r_we) begin
                        if (r_own == 1'(REQ_CONV)) w_rdata1_nxt = data_o;
                        else                       w_rdata0_nxt = data_o;
                    end
                    w_ack_nxt   = (r_own == 1'(REQ_CONV)) ? 2'b10 : 2'b01;
                    w_cyc_nxt   = 1'b0;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_err_nxt   = (r_own == 1'(REQ_CONV)) ? 2'b10 : 2'b01;
                    w_cyc_nxt   = 1'b0;
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
`endif
            end
            // The slave holds ack one cycle past cyc_i; wait it out before re-granting.
            ST_RELEASE: begin
                if (!sdram_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_ack    <= 2'b00;
            r_gnt    <= 2'b00;
            r_last   <= 1'b1;
            r_own    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 2'b00;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_we     <= w_we_nxt;
            r_sel    <= w_sel_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
            r_ack    <= w_ack_nxt;
            r_gnt    <= w_gnt_nxt;
            r_last   <= w_last_nxt;
            r_own    <= w_own_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign cyc_i    = r_cyc;
    assign stb_i    = r_cyc;
    assign we_i     = r_we;
    assign sel_i    = r_sel;
    assign addr_i   = r_addr;
    assign data_i   = r_wdata;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign m0_ack   = r_ack[0];
    assign m1_ack   = r_ack[1];
    assign gnt      = r_gnt;
`ifdef ARB_TIMEOUT_EN
    assign m_err    = r_err;
`else
    assign m_err    = 2'b00;
`endif

endmodule
